// File: rtl/debug_trace_sched_if.sv
// Commit-port and head-record handshake bundle for debug_trace_sched.
// The slave modport is the scheduler's view; the master modport is the core/serializer side.
interface debug_trace_sched_if;
    logic        c0_valid;
    logic [31:0] c0_pc;
    logic [31:0] c0_instr;
    logic [31:0] c0_wdata;
    logic        c1_valid;
    logic [31:0] c1_pc;
    logic [31:0] c1_instr;
    logic [31:0] c1_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_wdata;
    logic [1:0]  out_mode;

    modport master (
        output c0_valid, c0_pc, c0_instr, c0_wdata,
        output c1_valid, c1_pc, c1_instr, c1_wdata,
        output out_ready,
        input  out_valid, out_pc, out_instr, out_wdata, out_mode
    );

    modport slave (
        input  c0_valid, c0_pc, c0_instr, c0_wdata,
        input  c1_valid, c1_pc, c1_instr, c1_wdata,
        input  out_ready,
        output out_valid, out_pc, out_instr, out_wdata, out_mode
    );
endinterface

// File: rtl/debug_trace_sched.sv
// Dual-commit retired-instruction trace buffer: program-order FWFT FIFO with drop counter.
// Optional feature: define DEBUG_TRACE_DEDUP_EN to discard commits repeating the last pushed pc.
module debug_trace_sched #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [1:0]             mode,
    debug_trace_sched_if.slave     bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_W-1:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] wdata;
        logic [31:0] instr;
        logic [31:0] pc;
    } rec_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg, level_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    rec_t              mem [DEPTH];

    logic              capture;
    logic [1:0]        elig;
    logic [1:0]        cand;
    rec_t              rec_in [2];
    logic              push0, push1, drop0, drop1, pop;
    logic [LW-1:0]     free;
    logic [AW-1:0]     wr1_ptr;
    logic [DROP_W:0]   drop_sum;
    rec_t              head;

    assign rec_in[0] = '{mode: mode, wdata: bus.c0_wdata, instr: bus.c0_instr, pc: bus.c0_pc};
    assign rec_in[1] = '{mode: mode, wdata: bus.c1_wdata, instr: bus.c1_instr, pc: bus.c1_pc};

    // flush suppresses all capture so the drop counter is untouched that cycle
    assign capture = (state_reg == RUN) && en && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic port_valid;
            assign port_valid = (gi == 0) ? bus.c0_valid : bus.c1_valid;
            assign elig[gi]   = port_valid && capture && (rec_in[gi].pc != 32'd0);
        end
    endgenerate

`ifdef DEBUG_TRACE_DEDUP_EN
    logic [31:0] last_pc_reg, last_pc_next;
    logic [31:0] ref1_pc;

    assign cand[0] = elig[0] && (rec_in[0].pc != last_pc_reg);
    assign ref1_pc = push0 ? rec_in[0].pc : last_pc_reg;
    assign cand[1] = elig[1] && (rec_in[1].pc != ref1_pc);
    assign last_pc_next = push1 ? rec_in[1].pc : (push0 ? rec_in[0].pc : last_pc_reg);
`else
    assign cand = elig;
`endif

    // space is judged on the registered level only; a same-cycle pop gives no credit
    assign free  = LW'(DEPTH) - level_reg;
    assign push0 = cand[0] && (free != '0);
    assign drop0 = cand[0] && (free == '0);
    assign push1 = cand[1] && (free > LW'(push0));
    assign drop1 = cand[1] && !push1;

    assign pop     = (level_reg != '0) && bus.out_ready && !flush;
    assign wr1_ptr = wr_ptr_reg + AW'(push0);

    assign level_next = level_reg + LW'(push0) + LW'(push1) - LW'(pop);
    assign drop_sum   = {1'b0, drop_cnt_reg} + (DROP_W+1)'(drop0) + (DROP_W+1)'(drop1);
    assign drop_cnt_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            drop_cnt_reg <= drop_cnt_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + AW'(push0) + AW'(push1);
                rd_ptr_reg <= rd_ptr_reg + AW'(pop);
                level_reg  <= level_next;
            end
        end
    end

`ifdef DEBUG_TRACE_DEDUP_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            last_pc_reg <= '0;
        end else begin
            last_pc_reg <= last_pc_next;
        end
    end
`endif

    // push0 and push1 always target distinct slots
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr_reg] <= rec_in[0];
        if (push1) mem[wr1_ptr]    <= rec_in[1];
    end

    assign head          = mem[rd_ptr_reg];
    assign bus.out_valid = (level_reg != '0);
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
    assign bus.out_instr = bus.out_valid ? head.instr : '0;
    assign bus.out_wdata = bus.out_valid ? head.wdata : '0;
    assign bus.out_mode  = bus.out_valid ? head.mode  : '0;

    assign level    = level_reg;
    assign drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_debug_trace_sched.sv
// Bench for debug_trace_sched: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_debug_trace_sched;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst, en, flush;
    logic [1:0]        mode;
    logic [3:0]        level;
    logic [DROP_W-1:0] drop_cnt;

    debug_trace_sched_if bus();

    debug_trace_sched #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .mode     (mode),
        .bus      (bus),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [1:0]  mode;
    } rec_t;

    rec_t        mq[$];
    rec_t        mnew[$];
    int          m_drops = 0;
    bit          m_run   = 1'b0;
    logic [31:0] m_last  = '0;
    int          mfree;
    bit          mpop;
    logic        mv;
    logic [31:0] mpc, minstr, mwdata;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a record queue updated with the same inputs the DUT samples
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_drops = 0;
            m_run   = 1'b0;
            m_last  = '0;
        end else begin
            if (flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                mfree = DEPTH - mq.size();
                mpop  = (mq.size() != 0) && bus.out_ready;
                mnew.delete();
                for (int p = 0; p < 2; p++) begin
                    mv     = (p == 0) ? bus.c0_valid : bus.c1_valid;
                    mpc    = (p == 0) ? bus.c0_pc    : bus.c1_pc;
                    minstr = (p == 0) ? bus.c0_instr : bus.c1_instr;
                    mwdata = (p == 0) ? bus.c0_wdata : bus.c1_wdata;
                    if (mv && m_run && en && mpc != 0) begin
`ifdef DEBUG_TRACE_DEDUP_EN
                        if (mpc == m_last) continue;
`endif
                        if (mfree > 0) begin
                            mnew.push_back('{pc: mpc, instr: minstr, wdata: mwdata, mode: mode});
                            mfree--;
                            m_last = mpc;
                        end else if (m_drops < (1 << DROP_W) - 1) begin
                            m_drops++;
                        end
                    end
                end
                if (mpop) void'(mq.pop_front());
                foreach (mnew[i]) mq.push_back(mnew[i]);
            end
            m_run = en;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            chk("level", 64'(level), 64'(mq.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
            if (mq.size() != 0) begin
                chk("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
                chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
                chk("out_wdata", 64'(bus.out_wdata), 64'(mq[0].wdata));
                chk("out_mode", 64'(bus.out_mode), 64'(mq[0].mode));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input bit v0, input logic [31:0] p0, input bit v1, input logic [31:0] p1);
        bus.c0_valid = v0;
        bus.c0_pc    = p0;
        bus.c0_instr = p0 ^ 32'h5a5a_0000;
        bus.c0_wdata = ~p0;
        bus.c1_valid = v1;
        bus.c1_pc    = p1;
        bus.c1_instr = p1 ^ 32'h5a5a_0000;
        bus.c1_wdata = ~p1;
    endtask

    task automatic idle();
        bus.c0_valid = 1'b0;
        bus.c1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; mode = 2'd0;
        commit(1'b0, 32'd0, 1'b0, 32'd0);
        bus.out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // single record, immediate drain
        en = 1'b1; mode = 2'd1; bus.out_ready = 1'b1;
        step();
        commit(1'b1, 32'h1c00_0000, 1'b0, 32'd0);
        step(); idle();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_pc", 64'(bus.out_pc), 64'h1c00_0000);
        chk("t1_mode", 64'(bus.out_mode), 64'd1);
        step();
        chk("t1_level", 64'(level), 64'd0);

        // dual commit order, mode tag survives later mode change
        bus.out_ready = 1'b0; mode = 2'd2;
        commit(1'b1, 32'h100, 1'b1, 32'h104);
        step(); idle(); mode = 2'd0;
        chk("t2_level", 64'(level), 64'd2);
        chk("t2_head", 64'(bus.out_pc), 64'h100);
        chk("t2_mode", 64'(bus.out_mode), 64'd2);
        step();
        chk("t2_hold", 64'(bus.out_pc), 64'h100);
        bus.out_ready = 1'b1;
        step();
        chk("t2_second", 64'(bus.out_pc), 64'h104);
        step();
        bus.out_ready = 1'b0;
        chk("t2_empty", 64'(level), 64'd0);

        // fill to DEPTH, last cycle both dropped
        for (int k = 0; k < 5; k++) begin
            commit(1'b1, 32'h1000 + 32'(16 * k), 1'b1, 32'h1008 + 32'(16 * k));
            step();
        end
        idle();
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_drop", 64'(drop_cnt), 64'd2);

        // full + pop same cycle: no credit
        commit(1'b1, 32'h2000, 1'b1, 32'h2004);
        bus.out_ready = 1'b1;
        step(); idle();
        bus.out_ready = 1'b0;
        chk("t4_level", 64'(level), 64'd7);
        chk("t4_drop", 64'(drop_cnt), 64'd4);
        chk("t4_head", 64'(bus.out_pc), 64'h1008);

        // one slot free: c0 kept, c1 dropped
        commit(1'b1, 32'h3000, 1'b1, 32'h3004);
        step(); idle();
        chk("t3b_level", 64'(level), 64'd8);
        chk("t3b_drop", 64'(drop_cnt), 64'd5);

        // flush at level 5
        bus.out_ready = 1'b1;
        step(); step(); step();
        bus.out_ready = 1'b0;
        chk("t5_level5", 64'(level), 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_level", 64'(level), 64'd0);
        chk("t5_flush_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_flush_drop", 64'(drop_cnt), 64'd5);

        commit(1'b1, 32'd0, 1'b0, 32'd0);
        step(); idle();
        chk("t5_pc0", 64'(level), 64'd0);

        // en low: commits ignored, buffer drains
        commit(1'b1, 32'h400, 1'b1, 32'h404);
        step(); idle();
        chk("t5_fill", 64'(level), 64'd2);
        en = 1'b0; bus.out_ready = 1'b1;
        commit(1'b1, 32'h500, 1'b1, 32'h504);
        step();
        chk("t5_en_off", 64'(level), 64'd1);
        chk("t5_en_head", 64'(bus.out_pc), 64'h404);
        step(); step(); idle();
        chk("t5_drained", 64'(level), 64'd0);
        chk("t5_drop_kept", 64'(drop_cnt), 64'd5);
        bus.out_ready = 1'b0;

        // repeated pc
        en = 1'b1;
        step();
        commit(1'b1, 32'h200, 1'b0, 32'd0);
        step(); step(); step(); idle();
`ifdef DEBUG_TRACE_DEDUP_EN
        chk("t6_repeat", 64'(level), 64'd1);
`else
        chk("t6_repeat", 64'(level), 64'd3);
`endif
        commit(1'b1, 32'h300, 1'b1, 32'h300);
        step(); idle();
`ifdef DEBUG_TRACE_DEDUP_EN
        chk("t6_same_cycle", 64'(level), 64'd2);
`else
        chk("t6_same_cycle", 64'(level), 64'd5);
`endif
        chk("t6_drop", 64'(drop_cnt), 64'd5);

        bus.out_ready = 1'b1;
        repeat (8) step();
        chk("final_empty", 64'(level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
